// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-fetch bus bundle: instruction memory port,
//                D-stage next-PC controls, pipeline control and F/D outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [3:0]  npc_op_d;
  logic [31:0] rs_val_d;
  logic [31:0] rt_val_d;
  logic        stall;
  logic        exc_flush;
  logic        eret_flush;
  logic [31:0] epc;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        clr_instr_d;
  logic [4:0]  exc_code_d;
  logic        bd_d;

  // Fetch unit side
  modport master (
    output imem_addr, instr_d, pc_d, clr_instr_d, exc_code_d, bd_d,
    input  imem_rdata, npc_op_d, rs_val_d, rt_val_d, stall,
           exc_flush, eret_flush, epc
  );

  // Memory / decoder / control side
  modport slave (
    input  imem_addr, instr_d, pc_d, clr_instr_d, exc_code_d, bd_d,
    output imem_rdata, npc_op_d, rs_val_d, rt_val_d, stall,
           exc_flush, eret_flush, epc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : PC register, next-PC selection (branch/jump/JR resolved in
//                D), fetch address-error detection and the F/D register.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI    = 32'h0000_6ffc
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam logic [3:0] c_op_seq  = 4'b0000;
  localparam logic [3:0] c_op_beq  = 4'b0001;
  localparam logic [3:0] c_op_j    = 4'b0010;
  localparam logic [3:0] c_op_jr   = 4'b0011;
  localparam logic [3:0] c_op_bne  = 4'b0100;
  localparam logic [3:0] c_op_bgez = 4'b0101;
  localparam logic [3:0] c_op_bgtz = 4'b0110;
  localparam logic [3:0] c_op_blez = 4'b0111;
  localparam logic [3:0] c_op_bltz = 4'b1000;
  localparam logic [4:0] c_adel    = 5'd4;

  logic [31:0] pc_f_q,     pc_f_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic [31:0] fd_pc_q,    fd_pc_d;
  logic        fd_clr_q,   fd_clr_d;
  logic [4:0]  fd_exc_q,   fd_exc_d;
  logic        fd_bd_q,    fd_bd_d;

  logic [31:0] w_pc_f4;
  logic [31:0] w_pd4;
  logic [31:0] w_bt;
  logic [31:0] w_jt;
  logic [31:0] w_npc;
  logic        w_fetch_exc;
  logic        w_rs_zero;
  logic        w_rs_neg;

  // Target arithmetic and fetch-address legality (wraps silently, no overflow)
  always_comb begin
    w_pc_f4     = pc_f_q + 32'd4;
    w_pd4       = fd_pc_q + 32'd4;
    w_bt        = w_pd4 + {{14{fd_instr_q[15]}}, fd_instr_q[15:0], 2'b00};
    w_jt        = {w_pd4[31:28], fd_instr_q[25:0], 2'b00};
    w_fetch_exc = (pc_f_q[1:0] != 2'b00) || (pc_f_q < IMEM_LO) || (pc_f_q > IMEM_HI);
    w_rs_zero   = (bus.rs_val_d == 32'd0);
    w_rs_neg    = bus.rs_val_d[31];
  end

  // Next-PC select from the D-stage opcode; unknown opcodes fall through
  always_comb begin
    w_npc = w_pc_f4;
    case (bus.npc_op_d)
      c_op_seq:  w_npc = w_pc_f4;
      c_op_beq:  w_npc = (bus.rs_val_d == bus.rt_val_d) ? w_bt : w_pc_f4;
      c_op_bne:  w_npc = (bus.rs_val_d != bus.rt_val_d) ? w_bt : w_pc_f4;
      c_op_bgez: w_npc = !w_rs_neg                ? w_bt : w_pc_f4;
      c_op_bgtz: w_npc = (!w_rs_neg && !w_rs_zero) ? w_bt : w_pc_f4;
      c_op_blez: w_npc = (w_rs_neg || w_rs_zero)   ? w_bt : w_pc_f4;
      c_op_bltz: w_npc = w_rs_neg                 ? w_bt : w_pc_f4;
      c_op_j:    w_npc = w_jt;
      c_op_jr:   w_npc = bus.rs_val_d;
      default:   w_npc = w_pc_f4;
    endcase
  end

  // PC and F/D update with priority exc_flush > eret_flush > stall > normal
  always_comb begin
    pc_f_d     = pc_f_q;
    fd_instr_d = fd_instr_q;
    fd_pc_d    = fd_pc_q;
    fd_clr_d   = fd_clr_q;
    fd_exc_d   = fd_exc_q;
    fd_bd_d    = fd_bd_q;
    if (bus.exc_flush) begin
      pc_f_d     = HANDLER_PC;
      fd_instr_d = 32'd0;
      fd_pc_d    = HANDLER_PC;
      fd_clr_d   = 1'b0;
      fd_exc_d   = 5'd0;
      fd_bd_d    = 1'b0;
    end else if (bus.eret_flush) begin
      pc_f_d     = bus.epc;
      fd_instr_d = 32'd0;
      fd_pc_d    = bus.epc;
      fd_clr_d   = 1'b0;
      fd_exc_d   = 5'd0;
      fd_bd_d    = 1'b0;
    end else if (!bus.stall) begin
      // The instruction in F is the delay slot and always advances into D
      pc_f_d     = w_npc;
      fd_instr_d = w_fetch_exc ? 32'd0 : bus.imem_rdata;
      fd_pc_d    = pc_f_q;
      fd_clr_d   = w_fetch_exc;
      fd_exc_d   = w_fetch_exc ? c_adel : 5'd0;
      fd_bd_d    = (bus.npc_op_d != c_op_seq);
    end
  end

  // State registers; reset overrides every other control
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q     <= RESET_PC;
      fd_instr_q <= 32'd0;
      fd_pc_q    <= RESET_PC;
      fd_clr_q   <= 1'b0;
      fd_exc_q   <= 5'd0;
      fd_bd_q    <= 1'b0;
    end else begin
      pc_f_q     <= pc_f_d;
      fd_instr_q <= fd_instr_d;
      fd_pc_q    <= fd_pc_d;
      fd_clr_q   <= fd_clr_d;
      fd_exc_q   <= fd_exc_d;
      fd_bd_q    <= fd_bd_d;
    end
  end

  assign bus.imem_addr   = pc_f_q;
  assign bus.instr_d     = fd_instr_q;
  assign bus.pc_d        = fd_pc_q;
  assign bus.clr_instr_d = fd_clr_q;
  assign bus.exc_code_d  = fd_exc_q;
  assign bus.bd_d        = fd_bd_q;

endmodule
`default_nettype wire
